// File: rtl/lut_wvf_sequencer.sv
// Burst/rate controller for the LUT waveform generator.
// Paces the generator with one-cycle step pulses, counts completed waveform
// periods from the generator's end flag, and sequences NPER periods per burst,
// GAP idle cycles between bursts and NBURST bursts per run before pulsing DONE.
module lut_wvf_sequencer #(
   parameter int unsigned DIV_WIDTH = 12,
   parameter int unsigned CNT_WIDTH = 8,
   parameter int unsigned DEF_DIV   = 477
) (
   input  logic                 CLK_SYS,
   input  logic                 nRST,
   input  logic                 CFG_VALID,
   output logic                 CFG_READY,
   input  logic [DIV_WIDTH-1:0] CFG_DIV,
   input  logic [CNT_WIDTH-1:0] CFG_NPER,
   input  logic [DIV_WIDTH-1:0] CFG_GAP,
   input  logic [CNT_WIDTH-1:0] CFG_NBURST,
   input  logic                 START,
   input  logic                 STOP,
   input  logic                 LUT_END,
   output logic                 LUT_EN,
   output logic                 TRGG_CNT_FLAG,
   output logic                 BUSY,
   output logic                 DONE,
   output logic [1:0]           STATE
);

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_GAP  = 2'b10;

   localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEF_DIV);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   // configuration registers (written only while idle)
   logic [DIV_WIDTH-1:0] div_q;
   logic [CNT_WIDTH-1:0] nper_q;
   logic [DIV_WIDTH-1:0] gap_q;
   logic [CNT_WIDTH-1:0] nburst_q;

   // sequencing state
   logic [1:0]           state_q,     state_d;
   logic [DIV_WIDTH-1:0] div_cnt_q,   div_cnt_d;
   logic [CNT_WIDTH-1:0] per_cnt_q,   per_cnt_d;
   logic [CNT_WIDTH-1:0] burst_cnt_q, burst_cnt_d;
   logic [DIV_WIDTH-1:0] gap_cnt_q,   gap_cnt_d;
   logic                 lut_en_q,    lut_en_d;
   logic                 lut_end_q,   lut_end_d;
   logic                 done_q,      done_d;

   // decoded events
   logic [DIV_WIDTH-1:0] eff_div;
   logic [CNT_WIDTH-1:0] burst_inc;
   logic                 cfg_load;
   logic                 div_tick;
   logic                 run_edge;
   logic                 last_per;
   logic                 last_burst;

   // Decode step ticks, period ends and burst ends from the current state.
   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      eff_div    = (div_q == '0) ? DIV_ONE : div_q;
      burst_inc  = burst_cnt_q + CNT_ONE;
      cfg_load   = CFG_VALID && (state_q == ST_IDLE);
      div_tick   = (state_q == ST_RUN) && (div_cnt_q == eff_div - DIV_ONE);
      // lut_end_q tracks LUT_END while enabled, so re-entering RUN with the
      // generator parked on its last index produces no edge.
      run_edge   = (state_q == ST_RUN) && LUT_END && !lut_end_q;
      last_per   = run_edge && (nper_q != '0) && (per_cnt_q == nper_q - CNT_ONE);
      last_burst = (nburst_q != '0) && (burst_inc == nburst_q);
   end

   // Next-state logic for the IDLE/RUN/GAP sequencer and its counters.
   always_comb begin
      state_d     = state_q;
      div_cnt_d   = div_cnt_q;
      per_cnt_d   = per_cnt_q;
      burst_cnt_d = burst_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      lut_en_d    = lut_en_q;
      lut_end_d   = lut_en_q ? LUT_END : 1'b0;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (START && !STOP) begin
               state_d     = ST_RUN;
               lut_en_d    = 1'b1;
               div_cnt_d   = '0;
               per_cnt_d   = '0;
               burst_cnt_d = '0;
               gap_cnt_d   = '0;
            end
         end

         ST_RUN: begin
            if (STOP) begin
               state_d  = ST_IDLE;
               lut_en_d = 1'b0;
            end else begin
               div_cnt_d = div_tick ? '0 : div_cnt_q + DIV_ONE;
               if (run_edge) per_cnt_d = per_cnt_q + CNT_ONE;
               if (last_per) begin
                  burst_cnt_d = burst_inc;
                  per_cnt_d   = '0;
                  div_cnt_d   = '0;
                  if (last_burst) begin
                     state_d  = ST_IDLE;
                     lut_en_d = 1'b0;
                     done_d   = 1'b1;
                  end else if (gap_q != '0) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = '0;
                  end
               end
            end
         end

         ST_GAP: begin
            if (STOP) begin
               state_d  = ST_IDLE;
               lut_en_d = 1'b0;
            end else if (gap_cnt_q == gap_q - DIV_ONE) begin
               state_d   = ST_RUN;
               div_cnt_d = '0;
               per_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + DIV_ONE;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            lut_en_d = 1'b0;
         end
      endcase
   end

   // Sequencer registers with synchronous active-low reset.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK_SYS) begin
      if (!nRST) begin
         state_q     <= ST_IDLE;
         div_cnt_q   <= '0;
         per_cnt_q   <= '0;
         burst_cnt_q <= '0;
         gap_cnt_q   <= '0;
         lut_en_q    <= 1'b0;
         lut_end_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_cnt_q   <= div_cnt_d;
         per_cnt_q   <= per_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         lut_en_q    <= lut_en_d;
         lut_end_q   <= lut_end_d;
         done_q      <= done_d;
      end
   end

   // Configuration capture on the valid/ready handshake; reset restores defaults.
   always_ff @(posedge CLK_SYS) begin
      if (!nRST) begin
         div_q    <= DIV_RST;
         nper_q   <= CNT_ONE;
         gap_q    <= '0;
         nburst_q <= CNT_ONE;
      end else if (cfg_load) begin
         div_q    <= CFG_DIV;
         nper_q   <= CFG_NPER;
         gap_q    <= CFG_GAP;
         nburst_q <= CFG_NBURST;
      end
   end

   // The STOP cycle never steps the generator.
   assign TRGG_CNT_FLAG = div_tick && !last_per && !STOP;
   assign CFG_READY     = (state_q == ST_IDLE);
   assign BUSY          = (state_q != ST_IDLE);
   assign LUT_EN        = lut_en_q;
   assign DONE          = done_q;
   assign STATE         = state_q;

endmodule
